pipe_wb_reg: RTL and testbench

PIPE_WB_REG -- requirements
Module: pipe_wb_reg

---
 rtl/pipe_wb_reg_if.sv | 32 +++
 rtl/pipe_wb_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_wb_reg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_wb_reg_if.sv
// rtl/pipe_wb_reg_if.sv - write-back group bus: incoming instruction group and registered outputs
interface pipe_wb_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2
);
    logic                     in_valid;
    logic [NCH*ADDR_W-1:0]    in_wd;
    logic [NCH-1:0]           in_wreg;
    logic [NCH*DATA_W-1:0]    in_wdata;
    logic [DATA_W-1:0]        in_hi;
    logic [DATA_W-1:0]        in_lo;
    logic                     in_whilo;

    logic                     out_valid;
    logic [NCH*ADDR_W-1:0]    out_wd;
    logic [NCH-1:0]           out_wreg;
    logic [NCH*DATA_W-1:0]    out_wdata;
    logic [DATA_W-1:0]        out_hi;
    logic [DATA_W-1:0]        out_lo;
    logic                     out_whilo;

    modport master (
        output in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
        input  out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo
    );

    modport slave (
        input  in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo,
        output out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo
    );
endinterface

// File: rtl/pipe_wb_reg.sv
// rtl/pipe_wb_reg.sv - write-back pipeline register with flush/bubble/hold; optional PIPE_WB_PERF_CNT_EN counters
module pipe_wb_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NCH     = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    pipe_wb_reg_if.slave       wb
`ifdef PIPE_WB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubble,
    output logic [31:0]        perf_hold,
    output logic [31:0]        perf_flush
`endif
);

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_CAPTURE,
        ACT_HOLD
    } action_e;

    action_e act;

    // Zero-extended so the last stage reads a nonexistent downstream stall as 0.
    logic [STALL_W:0] stall_ext;
    logic             unused_stall;

    assign stall_ext    = {1'b0, stall};
    assign unused_stall = ^stall_ext;

    logic                  valid_q, valid_d;
    logic [NCH*ADDR_W-1:0] wd_q, wd_d;
    logic [NCH-1:0]        wreg_q, wreg_d;
    logic [NCH*DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  whilo_q, whilo_d;
    logic [NCH-1:0]        wreg_cap;

    always_comb begin
        act = ACT_HOLD;
        if (rst)
            act = ACT_RESET;
        else if (flush)
            act = ACT_FLUSH;
        else if (stall_ext[STAGE] && !stall_ext[STAGE+1])
            act = ACT_BUBBLE;
        else if (!stall_ext[STAGE])
            act = ACT_CAPTURE;
    end

    // A channel loses its write if it targets r0 or a later channel writes the same register.
    always_comb begin
        wreg_cap = '0;
        for (int i = 0; i < NCH; i++) begin
            wreg_cap[i] = wb.in_wreg[i] && (wb.in_wd[i*ADDR_W +: ADDR_W] != '0);
            for (int j = 0; j < NCH; j++) begin
                if (j > i && wb.in_wreg[j] &&
                    wb.in_wd[j*ADDR_W +: ADDR_W] == wb.in_wd[i*ADDR_W +: ADDR_W])
                    wreg_cap[i] = 1'b0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        case (act)
            ACT_CAPTURE: begin
                if (wb.in_valid) begin
                    valid_d = 1'b1;
                    wd_d    = wb.in_wd;
                    wreg_d  = wreg_cap;
                    wdata_d = wb.in_wdata;
                    hi_d    = wb.in_hi;
                    lo_d    = wb.in_lo;
                    whilo_d = wb.in_whilo;
                end else begin
                    valid_d = 1'b0;
                    wd_d    = '0;
                    wreg_d  = '0;
                    wdata_d = '0;
                    hi_d    = '0;
                    lo_d    = '0;
                    whilo_d = 1'b0;
                end
            end
            ACT_HOLD: ;
            default: begin
                valid_d = 1'b0;
                wd_d    = '0;
                wreg_d  = '0;
                wdata_d = '0;
                hi_d    = '0;
                lo_d    = '0;
                whilo_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
        end
    end

    assign wb.out_valid = valid_q;
    assign wb.out_wd    = wd_q;
    assign wb.out_wreg  = wreg_q;
    assign wb.out_wdata = wdata_q;
    assign wb.out_hi    = hi_q;
    assign wb.out_lo    = lo_q;
    assign wb.out_whilo = whilo_q;

`ifdef PIPE_WB_PERF_CNT_EN
    logic [31:0] perf_bubble_q, perf_hold_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_q <= '0;
            perf_hold_q   <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (act == ACT_BUBBLE) perf_bubble_q <= perf_bubble_q + 32'd1;
            if (act == ACT_HOLD)   perf_hold_q   <= perf_hold_q + 32'd1;
            if (act == ACT_FLUSH)  perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign perf_bubble = perf_bubble_q;
    assign perf_hold   = perf_hold_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_wb_reg.sv
// tb/tb_pipe_wb_reg.sv - directed and random checks of pipe_wb_reg (STAGE=4 and STAGE=5) against a reference model
module tb_pipe_wb_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;

    always #5 clk = ~clk;

    pipe_wb_reg_if #(.DATA_W(32), .ADDR_W(5), .NCH(2)) wb4 ();
    pipe_wb_reg_if #(.DATA_W(32), .ADDR_W(5), .NCH(2)) wb5 ();

    assign wb5.in_valid = wb4.in_valid;
    assign wb5.in_wd    = wb4.in_wd;
    assign wb5.in_wreg  = wb4.in_wreg;
    assign wb5.in_wdata = wb4.in_wdata;
    assign wb5.in_hi    = wb4.in_hi;
    assign wb5.in_lo    = wb4.in_lo;
    assign wb5.in_whilo = wb4.in_whilo;

`ifdef PIPE_WB_PERF_CNT_EN
    logic [31:0] pb4, ph4, pf4, pb5, ph5, pf5;
`endif

    pipe_wb_reg #(.DATA_W(32), .ADDR_W(5), .NCH(2), .STALL_W(6), .STAGE(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .wb(wb4)
`ifdef PIPE_WB_PERF_CNT_EN
        , .perf_bubble(pb4), .perf_hold(ph4), .perf_flush(pf4)
`endif
    );

    pipe_wb_reg #(.DATA_W(32), .ADDR_W(5), .NCH(2), .STALL_W(6), .STAGE(5)) dut5 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .wb(wb5)
`ifdef PIPE_WB_PERF_CNT_EN
        , .perf_bubble(pb5), .perf_hold(ph5), .perf_flush(pf5)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Reference state, index 0 = STAGE 4 instance, index 1 = STAGE 5 instance
    logic        m_valid [2];
    logic [9:0]  m_wd    [2];
    logic [1:0]  m_wreg  [2];
    logic [63:0] m_wdata [2];
    logic [31:0] m_hi    [2];
    logic [31:0] m_lo    [2];
    logic        m_whilo [2];
    int unsigned m_bub   [2];
    int unsigned m_hold  [2];
    int unsigned m_fl    [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble(input int d);
        m_valid[d] = 1'b0; m_wd[d] = '0; m_wreg[d] = '0; m_wdata[d] = '0;
        m_hi[d] = '0; m_lo[d] = '0; m_whilo[d] = 1'b0;
    endtask

    task automatic model_step(input int d, input int st);
        logic        here, after;
        logic [31:0] seen;
        logic [4:0]  a;
        here  = stall[st];
        after = 1'b0;
        if (st < 5) after = stall[st+1];
        if (rst) begin
            m_bubble(d);
            m_bub[d] = 0; m_hold[d] = 0; m_fl[d] = 0;
        end else if (flush) begin
            m_bubble(d);
            m_fl[d] = m_fl[d] + 1;
        end else if (here && !after) begin
            m_bubble(d);
            m_bub[d] = m_bub[d] + 1;
        end else if (here) begin
            m_hold[d] = m_hold[d] + 1;
        end else if (!wb4.in_valid) begin
            m_bubble(d);
        end else begin
            m_valid[d] = 1'b1;
            m_wd[d]    = wb4.in_wd;
            m_wdata[d] = wb4.in_wdata;
            m_hi[d]    = wb4.in_hi;
            m_lo[d]    = wb4.in_lo;
            m_whilo[d] = wb4.in_whilo;
            // Walk from the youngest channel; an address already claimed is not written again.
            seen = '0;
            for (int k = 1; k >= 0; k--) begin
                a = wb4.in_wd[k*5 +: 5];
                m_wreg[d][k] = wb4.in_wreg[k] && (a != 0) && !seen[a];
                if (wb4.in_wreg[k]) seen[a] = 1'b1;
            end
        end
    endtask

    task automatic check_dut(input int d, input string tag);
        logic        ov, ow;
        logic [9:0]  owd;
        logic [1:0]  owr;
        logic [63:0] odat;
        logic [31:0] ohi, olo;
        if (d == 0) begin
            ov = wb4.out_valid; owd = wb4.out_wd; owr = wb4.out_wreg; odat = wb4.out_wdata;
            ohi = wb4.out_hi; olo = wb4.out_lo; ow = wb4.out_whilo;
        end else begin
            ov = wb5.out_valid; owd = wb5.out_wd; owr = wb5.out_wreg; odat = wb5.out_wdata;
            ohi = wb5.out_hi; olo = wb5.out_lo; ow = wb5.out_whilo;
        end
        chk({tag, "_valid"}, 64'(ov),   64'(m_valid[d]));
        chk({tag, "_wd"},    64'(owd),  64'(m_wd[d]));
        chk({tag, "_wreg"},  64'(owr),  64'(m_wreg[d]));
        chk({tag, "_wdata"}, odat,      m_wdata[d]);
        chk({tag, "_hi"},    64'(ohi),  64'(m_hi[d]));
        chk({tag, "_lo"},    64'(olo),  64'(m_lo[d]));
        chk({tag, "_whilo"}, 64'(ow),   64'(m_whilo[d]));
`ifdef PIPE_WB_PERF_CNT_EN
        chk({tag, "_pbub"},  64'(d == 0 ? pb4 : pb5), 64'(m_bub[d]));
        chk({tag, "_phold"}, 64'(d == 0 ? ph4 : ph5), 64'(m_hold[d]));
        chk({tag, "_pfl"},   64'(d == 0 ? pf4 : pf5), 64'(m_fl[d]));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 5);
        #1;
        check_dut(0, {tag, "_s4"});
        check_dut(1, {tag, "_s5"});
    endtask

    task automatic set_in(input logic v, input logic [9:0] wd, input logic [1:0] wreg,
                          input logic [63:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                          input logic whilo);
        wb4.in_valid = v; wb4.in_wd = wd; wb4.in_wreg = wreg; wb4.in_wdata = wdata;
        wb4.in_hi = hi; wb4.in_lo = lo; wb4.in_whilo = whilo;
    endtask

    initial begin
`ifdef PIPE_WB_PERF_CNT_EN
        int unsigned hold_before;
`endif
        rst = 1'b1; flush = 1'b0; stall = 6'b000000;
        set_in(1'b1, {5'd3, 5'd7}, 2'b11, 64'h1234_5678_9ABC_DEF0, 32'h1, 32'h2, 1'b1);
        tick("reset");
        chk("reset_valid", 64'(wb4.out_valid), 64'd0);

        rst = 1'b0;
        set_in(1'b1, {5'd8, 5'd8}, 2'b11, {32'h22, 32'h11}, 32'h0, 32'h0, 1'b0);
        tick("same_dest");
        chk("same_dest_wreg", 64'(wb4.out_wreg), 64'b10);
        chk("same_dest_wdata", wb4.out_wdata, 64'h00000022_00000011);

        set_in(1'b1, {5'd0, 5'd9}, 2'b01, {32'h0, 32'hABCD0000}, 32'h0, 32'h0, 1'b0);
        tick("cap9");
`ifdef PIPE_WB_PERF_CNT_EN
        hold_before = ph4;
`endif
        stall = 6'b110000;
        set_in(1'b1, {5'd4, 5'd4}, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7, 32'h7, 1'b1);
        for (int i = 0; i < 3; i++) tick("hold");
        chk("hold_wdata", wb4.out_wdata, 64'h00000000_ABCD0000);
`ifdef PIPE_WB_PERF_CNT_EN
        chk("hold_count", 64'(ph4 - hold_before), 64'd3);
`endif

        stall = 6'b010000;
        set_in(1'b1, 10'd0, 2'b00, 64'd0, 32'h5, 32'h0, 1'b1);
        tick("bubble");
        chk("bubble_hi", 64'(wb4.out_hi), 64'd0);

        stall = 6'b000000;
        set_in(1'b1, {5'd2, 5'd1}, 2'b11, 64'hAAAA_BBBB_CCCC_DDDD, 32'h9, 32'h8, 1'b1);
        tick("cap_pre_flush");
        stall = 6'b110000;
        tick("hold_pre_flush");
        flush = 1'b1;
        tick("flush_in_hold");
        rst = 1'b1;
        tick("flush_rst");
        rst = 1'b0; flush = 1'b0; stall = 6'b000000;

        set_in(1'b1, {5'd6, 5'd0}, 2'b11, 64'h0000_0006_0000_0000, 32'h0, 32'h0, 1'b0);
        tick("r0");
        chk("r0_wreg", 64'(wb4.out_wreg), 64'b10);
        stall = 6'b100000;
        tick("last_stage");
        chk("last_stage_valid", 64'(wb5.out_valid), 64'd0);

        stall = 6'b000000;
        set_in(1'b0, {5'd6, 5'd5}, 2'b11, 64'h1, 32'h1, 32'h1, 1'b1);
        tick("invalid_cap");

        for (int n = 0; n < 300; n++) begin
            rst   = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 8);
            stall = 6'($urandom);
            if ($urandom_range(0, 1) == 0) stall[5:4] = 2'b00;
            set_in(1'($urandom), {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                   2'($urandom), {$urandom, $urandom}, $urandom, $urandom, 1'($urandom));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
